// File: rtl/ps2_key_event_tracker.sv
// ps2_key_event_tracker: PS/2 set-2 scancode decoder tracking NUM_KEYS keys
// (plain and E0-extended). It drives per-key hold/pulse outputs and queues
// make/break events in a first-word-fall-through FIFO with valid/ready.
// Optional build macro PS2_PREFIX_TIMEOUT_EN adds TIMEOUT_CYCLES, which
// returns a stalled prefix sequence (E0/F0) to MAKE after that many idle cycles.
module ps2_key_event_tracker #(
    parameter int                    NUM_KEYS   = 10,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES  = {9'h05A, 9'h029, 9'h172, 9'h175, 9'h174,
                                                   9'h16B, 9'h023, 9'h01B, 9'h01C, 9'h01D},
    parameter logic [NUM_KEYS-1:0]   PULSE_MASK = '0,
    parameter int                    FIFO_DEPTH = 8
`ifdef PS2_PREFIX_TIMEOUT_EN
    ,
    parameter int                    TIMEOUT_CYCLES = 1_000_000
`endif
) (
    input  logic                                               clock,
    input  logic                                               reset,
    input  logic                                               byte_valid,
    input  logic [7:0]                                         byte_data,
    output logic [NUM_KEYS-1:0]                                key_state,
    output logic [NUM_KEYS-1:0]                                key_out,
    output logic                                               keys_any,
    output logic                                               evt_valid,
    input  logic                                               evt_ready,
    output logic [((NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1)-1:0] evt_key,
    output logic                                               evt_make,
    output logic                                               evt_overflow
);

    localparam int KIW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_MAKE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_SEC_MAKE  = 2'd2,
        ST_SEC_BREAK = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                code_valid;
    logic                code_ext;
    logic                code_press;

    logic [NUM_KEYS-1:0] keys_q, keys_d;
    logic [NUM_KEYS-1:0] out_q, out_d;
    logic                evt_push;
    logic [KIW-1:0]      evt_idx;

    logic [KIW:0]        fifo_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_q, wr_d;
    logic [PW-1:0]       rd_q, rd_d;
    logic [PW:0]         cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                pop;
    logic                full;
    logic                push_ok;

`ifdef PS2_PREFIX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]       to_q, to_d;
`endif

    // The prefix state seen before a code byte decides extended/press.
    assign code_ext   = (state_q == ST_SEC_MAKE) || (state_q == ST_SEC_BREAK);
    assign code_press = (state_q == ST_MAKE) || (state_q == ST_SEC_MAKE);

    // Decoder next state: prefixes advance the FSM, any code byte returns to MAKE.
    always_comb begin
        state_d    = state_q;
        code_valid = 1'b0;
`ifdef PS2_PREFIX_TIMEOUT_EN
        to_d       = '0;
`endif
        if (byte_valid) begin
            case (byte_data)
                8'hE0: state_d = ST_SEC_MAKE;
                8'hF0: begin
                    if (state_q == ST_MAKE)          state_d = ST_BREAK;
                    else if (state_q == ST_SEC_MAKE) state_d = ST_SEC_BREAK;
                end
                8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE: state_d = ST_MAKE;
                default: begin
                    state_d    = ST_MAKE;
                    code_valid = 1'b1;
                end
            endcase
        end
`ifdef PS2_PREFIX_TIMEOUT_EN
        else if (state_q != ST_MAKE) begin
            if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_MAKE;
            end else begin
                to_d = to_q + TW'(1);
            end
        end
`endif
    end

    // Key matching: every matching key updates, the lowest changed index is reported.
    always_comb begin
        keys_d   = keys_q;
        evt_push = 1'b0;
        evt_idx  = '0;
        if (code_valid) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (KEY_CODES[9*i +: 9] == {code_ext, byte_data}) begin
                    keys_d[i] = code_press;
                    if ((keys_q[i] != code_press) && !evt_push) begin
                        evt_push = 1'b1;
                        evt_idx  = KIW'(i);
                    end
                end
            end
        end
        out_d = (keys_d & ~keys_q & PULSE_MASK) | (keys_d & ~PULSE_MASK);
    end

    assign pop     = (cnt_q != '0) && evt_ready;
    assign full    = (cnt_q == (PW+1)'(FIFO_DEPTH));
    assign push_ok = evt_push && (!full || pop);

    // FIFO bookkeeping; a push into a full FIFO survives only if the head leaves this cycle.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q | (evt_push && !push_ok);
        if (push_ok) wr_d = wr_q + PW'(1);
        if (pop)     rd_d = rd_q + PW'(1);
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control and key state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_MAKE;
            keys_q  <= '0;
            out_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef PS2_PREFIX_TIMEOUT_EN
            to_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            keys_q  <= keys_d;
            out_q   <= out_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
`ifdef PS2_PREFIX_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end

    // Event storage; contents are only meaningful between the pointers.
    always_ff @(posedge clock) begin
        if (push_ok) fifo_q[wr_q] <= {evt_idx, code_press};
    end

    assign key_state    = keys_q;
    assign key_out      = out_q;
    assign keys_any     = |keys_q;
    assign evt_valid    = (cnt_q != '0);
    assign evt_key      = evt_valid ? fifo_q[rd_q][KIW:1] : '0;
    assign evt_make     = evt_valid & fifo_q[rd_q][0];
    assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_tracker.sv
// Testbench for ps2_key_event_tracker: directed scenarios plus a randomized
// byte stream checked against a behavioural model of the decoding rules.
module tb_ps2_key_event_tracker;

    localparam int         NK    = 10;
    localparam int         DEPTH = 4;
    localparam logic [9:0] MASK  = 10'h100;
`ifdef PS2_PREFIX_TIMEOUT_EN
    localparam int         TO    = 16;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       evt_ready = 1'b0;
    logic [9:0] key_state;
    logic [9:0] key_out;
    logic       keys_any;
    logic       evt_valid;
    logic [3:0] evt_key;
    logic       evt_make;
    logic       evt_overflow;

    always #5 clock = ~clock;

    ps2_key_event_tracker #(
        .PULSE_MASK (MASK),
        .FIFO_DEPTH (DEPTH)
`ifdef PS2_PREFIX_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .key_state    (key_state),
        .key_out      (key_out),
        .keys_any     (keys_any),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_key      (evt_key),
        .evt_make     (evt_make),
        .evt_overflow (evt_overflow)
    );

    // Key table: W A S D LEFT RIGHT UP DOWN SPACE ENTER (bit 8 = E0 extended)
    int         codes [NK] = '{'h01D, 'h01C, 'h01B, 'h023, 'h16B, 'h174, 'h175, 'h172, 'h029, 'h05A};
    logic [7:0] specials [5] = '{8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE};

    // Reference model state
    bit [9:0] m_keys;
    bit [9:0] m_out;
    int       q_key [$];
    bit       q_make [$];
    bit       m_ovf;
    bit       m_ext;
    bit       m_brk;
    int       m_idle;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_edge(input bit rst, input bit bv, input bit [7:0] bd, input bit rdy);
        bit [9:0] nk;
        bit       ev;
        int       ek;
        bit       em;
        bit       pop;
        bit [8:0] code;
        if (rst) begin
            m_keys = '0; m_out = '0; q_key.delete(); q_make.delete();
            m_ovf = 0; m_ext = 0; m_brk = 0; m_idle = 0;
            return;
        end
        pop = (q_key.size() > 0) && rdy;
        nk = m_keys; ev = 0; ek = 0; em = 0;
        if (bv) begin
            m_idle = 0;
            if (bd == 8'hE0) begin
                m_ext = 1; m_brk = 0;
            end else if (bd == 8'hF0) begin
                m_brk = 1;
            end else if (bd inside {8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE}) begin
                m_ext = 0; m_brk = 0;
            end else begin
                code = {m_ext, bd};
                for (int i = 0; i < NK; i++) begin
                    if (codes[i] == int'(code) && nk[i] != !m_brk) begin
                        nk[i] = !m_brk;
                        if (!ev) begin ev = 1; ek = i; em = !m_brk; end
                    end
                end
                m_ext = 0; m_brk = 0;
            end
        end else begin
`ifdef PS2_PREFIX_TIMEOUT_EN
            if (m_ext || m_brk) begin
                m_idle++;
                if (m_idle == TO) begin m_ext = 0; m_brk = 0; m_idle = 0; end
            end
`endif
        end
        m_out  = (nk & ~m_keys & MASK) | (nk & ~MASK);
        m_keys = nk;
        if (pop) begin void'(q_key.pop_front()); void'(q_make.pop_front()); end
        if (ev) begin
            if (q_key.size() < DEPTH) begin q_key.push_back(ek); q_make.push_back(em); end
            else m_ovf = 1;
        end
    endtask

    task automatic step(input bit rst, input bit bv, input bit [7:0] bd, input bit rdy);
        reset = rst; byte_valid = bv; byte_data = bd; evt_ready = rdy;
        @(posedge clock);
        model_edge(rst, bv, bd, rdy);
        #1;
        reset = 1'b0; byte_valid = 1'b0; evt_ready = 1'b0;
    endtask

    task automatic send(input bit [7:0] bd, input bit rdy);
        step(1'b0, 1'b1, bd, rdy);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 8'h00, rdy);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        n_tests++;
        if ({key_state, key_out, keys_any} !== 21'd0) begin
            n_fail++; $display("FAIL reset_keys: got %h required 0", {key_state, key_out, keys_any});
        end
        n_tests++;
        if ({evt_valid, evt_key, evt_make, evt_overflow} !== 7'd0) begin
            n_fail++; $display("FAIL reset_fifo: got %h required 0", {evt_valid, evt_key, evt_make, evt_overflow});
        end
    endtask

    task automatic test_make_break();
        send(8'h1D, 1'b0);
        n_tests++;
        if (key_state !== 10'h001 || keys_any !== 1'b1) begin
            n_fail++; $display("FAIL mb_press: got %h/%b required 001/1", key_state, keys_any);
        end
        n_tests++;
        if ({evt_valid, evt_key, evt_make} !== {1'b1, 4'd0, 1'b1}) begin
            n_fail++; $display("FAIL mb_press_evt: got %b/%0d/%b required 1/0/1", evt_valid, evt_key, evt_make);
        end
        idle(1'b0);
        n_tests++;
        if (key_out !== 10'h001) begin
            n_fail++; $display("FAIL mb_hold_out: got %h required 001", key_out);
        end
        send(8'hF0, 1'b0);
        n_tests++;
        if (key_state !== 10'h001) begin
            n_fail++; $display("FAIL mb_f0_nochange: got %h required 001", key_state);
        end
        send(8'h1D, 1'b0);
        n_tests++;
        if (key_state !== 10'h000 || key_out !== 10'h000) begin
            n_fail++; $display("FAIL mb_release: got %h/%h required 000/000", key_state, key_out);
        end
        idle(1'b1);
        n_tests++;
        if ({evt_valid, evt_key, evt_make} !== {1'b1, 4'd0, 1'b0}) begin
            n_fail++; $display("FAIL mb_second_evt: got %b/%0d/%b required 1/0/0", evt_valid, evt_key, evt_make);
        end
        idle(1'b1);
        n_tests++;
        if (evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL mb_drained: got %b required 0", evt_valid);
        end
    endtask

    task automatic test_extended();
        send(8'hE0, 1'b1);
        send(8'h75, 1'b1);
        n_tests++;
        if (key_state !== 10'h040 || {evt_valid, evt_key, evt_make} !== {1'b1, 4'd6, 1'b1}) begin
            n_fail++; $display("FAIL ext_press: got %h %b/%0d/%b required 040 1/6/1", key_state, evt_valid, evt_key, evt_make);
        end
        send(8'h75, 1'b1);
        n_tests++;
        if (key_state !== 10'h040 || evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL ext_plain_ignored: got %h %b required 040 0", key_state, evt_valid);
        end
        send(8'hE0, 1'b1);
        send(8'hF0, 1'b1);
        send(8'h75, 1'b1);
        n_tests++;
        if (key_state !== 10'h000 || {evt_valid, evt_key, evt_make} !== {1'b1, 4'd6, 1'b0}) begin
            n_fail++; $display("FAIL ext_release: got %h %b/%0d/%b required 000 1/6/0", key_state, evt_valid, evt_key, evt_make);
        end
        idle(1'b1);
    endtask

    task automatic test_typematic_pulse();
        int seen;
        send(8'h29, 1'b0);
        n_tests++;
        if (key_out !== 10'h100 || key_state !== 10'h100) begin
            n_fail++; $display("FAIL pulse_first: got out %h state %h required 100/100", key_out, key_state);
        end
        idle(1'b0);
        n_tests++;
        if (key_out !== 10'h000 || key_state !== 10'h100) begin
            n_fail++; $display("FAIL pulse_one_cycle: got out %h state %h required 000/100", key_out, key_state);
        end
        send(8'h29, 1'b0);
        send(8'h29, 1'b0);
        n_tests++;
        if (key_out !== 10'h000 || key_state !== 10'h100) begin
            n_fail++; $display("FAIL pulse_repeat: got out %h state %h required 000/100", key_out, key_state);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (evt_valid) seen++;
            idle(1'b1);
        end
        n_tests++;
        if (seen != 1) begin
            n_fail++; $display("FAIL pulse_event_count: got %0d required 1", seen);
        end
        send(8'hF0, 1'b1);
        send(8'h29, 1'b1);
        idle(1'b1);
    endtask

    task automatic test_overflow();
        int exp_k [4] = '{1, 2, 3, 0};
        bit exp_m [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        send(8'h1D, 1'b0);
        send(8'h1C, 1'b0);
        send(8'h1B, 1'b0);
        send(8'h23, 1'b0);
        n_tests++;
        if (evt_valid !== 1'b1 || evt_overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_full_no_drop: got valid %b ovf %b required 1/0", evt_valid, evt_overflow);
        end
        send(8'hF0, 1'b0);
        send(8'h1D, 1'b1);
        n_tests++;
        if (evt_overflow !== 1'b0 || {evt_key, evt_make} !== {4'd1, 1'b1}) begin
            n_fail++; $display("FAIL ovf_pop_push: got ovf %b head %0d/%b required 0 1/1", evt_overflow, evt_key, evt_make);
        end
        send(8'hE0, 1'b0);
        send(8'h6B, 1'b0);
        n_tests++;
        if (evt_overflow !== 1'b1 || key_state !== 10'h01E) begin
            n_fail++; $display("FAIL ovf_drop: got ovf %b state %h required 1/01E", evt_overflow, key_state);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({evt_valid, evt_key, evt_make} !== {1'b1, 4'(exp_k[i]), exp_m[i]}) begin
                n_fail++; $display("FAIL ovf_order[%0d]: got %b/%0d/%b required 1/%0d/%b", i, evt_valid, evt_key, evt_make, exp_k[i], exp_m[i]);
            end
            idle(1'b1);
        end
        n_tests++;
        if (evt_valid !== 1'b0 || evt_overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky: got valid %b ovf %b required 0/1", evt_valid, evt_overflow);
        end
    endtask

    task automatic test_reset_prefix();
        send(8'hE0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        n_tests++;
        if ({key_state, key_out, keys_any, evt_valid, evt_key, evt_make, evt_overflow} !== 28'd0) begin
            n_fail++; $display("FAIL rstp_outputs: got %h required 0", {key_state, key_out, keys_any, evt_valid, evt_key, evt_make, evt_overflow});
        end
        send(8'h6B, 1'b0);
        n_tests++;
        if (key_state !== 10'h000 || evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstp_prefix_cleared: got %h %b required 000 0", key_state, evt_valid);
        end
    endtask

    task automatic test_prefix_timing();
`ifdef PS2_PREFIX_TIMEOUT_EN
        send(8'hE0, 1'b0);
        for (int i = 0; i < 20; i++) idle(1'b0);
        send(8'h6B, 1'b0);
        n_tests++;
        if (key_state !== 10'h000) begin
            n_fail++; $display("FAIL timeout_expired: got %h required 000", key_state);
        end
        send(8'hE0, 1'b0);
        for (int i = 0; i < 10; i++) idle(1'b0);
        send(8'h6B, 1'b0);
        n_tests++;
        if (key_state !== 10'h010) begin
            n_fail++; $display("FAIL timeout_not_expired: got %h required 010", key_state);
        end
`else
        send(8'hE0, 1'b0);
        for (int i = 0; i < 30; i++) idle(1'b0);
        send(8'h6B, 1'b0);
        n_tests++;
        if (key_state !== 10'h010) begin
            n_fail++; $display("FAIL prefix_persists: got %h required 010", key_state);
        end
`endif
    endtask

    task automatic test_random();
        bit       rst;
        bit       bv;
        bit [7:0] bd;
        bit       rdy;
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            bv  = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 7))
                0, 1, 2: bd = 8'(codes[$urandom_range(0, NK-1)]);
                3:       bd = 8'hE0;
                4:       bd = 8'hF0;
                5:       bd = specials[$urandom_range(0, 4)];
                default: bd = 8'($urandom);
            endcase
            step(rst, bv, bd, rdy);
            n_tests++;
            if (key_state !== m_keys || keys_any !== (|m_keys)) begin
                n_fail++; $display("FAIL rnd_state c%0d: got %h/%b required %h/%b", c, key_state, keys_any, m_keys, |m_keys);
            end
            n_tests++;
            if (key_out !== m_out) begin
                n_fail++; $display("FAIL rnd_key_out c%0d: got %h required %h", c, key_out, m_out);
            end
            n_tests++;
            if (evt_valid !== (q_key.size() != 0) || evt_overflow !== m_ovf) begin
                n_fail++; $display("FAIL rnd_fifo_flags c%0d: got %b/%b required %b/%b", c, evt_valid, evt_overflow, q_key.size() != 0, m_ovf);
            end
            if (q_key.size() != 0) begin
                n_tests++;
                if (evt_key !== 4'(q_key[0]) || evt_make !== q_make[0]) begin
                    n_fail++; $display("FAIL rnd_head c%0d: got %0d/%b required %0d/%b", c, evt_key, evt_make, q_key[0], q_make[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_typematic_pulse();
        test_overflow();
        test_reset_prefix();
        test_prefix_timing();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
